alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the ALU top.
- Captures each ALU result, its opcode-qualified flags and a destination tag into a small FIFO.
- Presents entries to the writeback consumer over a valid/ready handshake.
- On commit (pop), maintains an architectural NZCV status register, breaking the ALU's combinational path before writeback.

Parameters:
- WIDTH, 32, datapath width; matches ALU operand/result width.
- DEPTH, 2, FIFO entries; power of two, ≥2.
- TAG_W, 5, destination-register tag width.

Ports:
- clk  input  1  single clock, all state rising-edge.
- rst_n  input  1  asynchronous active-low reset; deassertion synchronised externally.
- in_valid  input  1  ALU result valid this cycle.
- in_ready  output  1  stage can accept; equals not-full, registered-state only (no out_ready path).
- in_result  input  WIDTH  ALU alu_out.
- in_aluop  input  5  opcode that produced in_result.
- in_tag  input  TAG_W  destination tag.
- in_cout  input  1  adder carry-out.
- in_neg  input  1  adder negative flag.
- in_ovf  input  1  adder overflow flag.
- in_zero  input  1  adder zero flag.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts head.
- out_result  output  WIDTH  head result.
- out_tag  output  TAG_W  head tag.
- out_flags  output  4  head flags {N,Z,C,V}.
- status_nzcv  output  4  architectural flags, updated on commit.

Behaviour:
- Push = in_valid & in_ready; pop = out_valid & out_ready. Both may occur in one cycle.
- When full, in_ready=0 even if out_ready=1 in the same cycle; no push that cycle.
- Flag formation at push:
  - Arithmetic ops (aluop 5'b00001, 5'b00011): flags = {in_neg, in_zero, in_cout, in_ovf}.
  - All other ops: N = in_result[WIDTH-1], Z = (in_result==0), C = 0, V = 0.
- Storage: circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH; count of $clog2(DEPTH)+1 bits.
  - Push only: count+1. Pop only: count−1. Both: count unchanged.
- out_* are driven from the head entry, so latency in→out is 1 cycle minimum. out_* hold stable while out_valid & !out_ready.
- out_valid = (count!=0); in_ready = (count!=DEPTH).
- status_nzcv: on pop, loaded with head flags only if the head aluop is arithmetic or logical (5'b00001–5'b10000); otherwise (undefined opcodes) it holds. Undefined opcodes are still stored, result passes through as given.
- Empty with simultaneous push: entry is not bypassed; it appears next cycle.
- Reset (async, any time including mid-transfer): pointers, count, status_nzcv → 0. out_valid=0, in_ready=1. Entry contents don't-care; out_result/out_tag/out_flags read 0 via reset-cleared storage.

Optional Feature:
- Macro ALU_RESULT_STATS_EN.
- Defined: adds outputs stat_commits[31:0] (increments on every pop) and stat_ovf[31:0] (increments on pop of an arithmetic entry with V=1). Both wrap at 2^32 and reset to 0.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package alu_pkg:
  - opcode localparams (ALU_ADD=5'b00001, ALU_SUB=5'b00011, … ALU_NOT=5'b10000).
  - function is_arith(aluop).
  - flag index constants FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0.
- One sub-module: alu_result_fifo (generic WIDTH-agnostic payload FIFO, DEPTH entries, push/pop/full/empty). Flag formation and the status register stay in the top.

Test Plan:
- Reset then single ADD push (result 0x0000_0005, cout=0, ovf=0, tag=3) with out_ready=1 → out_valid next cycle, out_result=5, out_tag=3, out_flags=4'b0000; status_nzcv=0000 after the pop.
- Fill: push two results with out_ready=0 → in_ready=0 after the 2nd push; a 3rd in_valid is ignored; draining pops in order.
- Simultaneous push/pop at count=1 for 8 cycles → count stays 1, ordering preserved, no drops, pointers wrap cleanly.
- SUB 0x7FFF_FFFF−0xFFFF_FFFF with adder ovf=1, neg=1 → out_flags=4'b1001 (C per in_cout); status_nzcv updates only on the pop cycle.
- AND result 0 with in_cout=1 → out_flags=4'b0100 (C forced 0); undefined aluop 5'b11111 popped → status_nzcv unchanged.
- Assert rst_n low while 2 entries are pending and out_ready=0 → immediately out_valid=0, in_ready=1, status_nzcv=0; with ALU_RESULT_STATS_EN, counters also read 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcodes, flag indices and opcode classifiers for the
// ALU result stage.
package alu_pkg;

  localparam logic [4:0] ALU_ADD = 5'b00001;
  localparam logic [4:0] ALU_SUB = 5'b00011;
  localparam logic [4:0] ALU_AND = 5'b00100;
  localparam logic [4:0] ALU_OR  = 5'b00101;
  localparam logic [4:0] ALU_XOR = 5'b00110;
  localparam logic [4:0] ALU_NOT = 5'b10000;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  function automatic logic is_arith(
    input logic [4:0] aluop
  );
    return (aluop == ALU_ADD) ||
           (aluop == ALU_SUB);
  endfunction

  // Opcodes 1..16 are defined and may touch the status register.
  function automatic logic is_defined(
    input logic [4:0] aluop
  );
    return (aluop >= ALU_ADD) &&
           (aluop <= ALU_NOT);
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Payload-agnostic circular FIFO with reset-cleared storage.
// Pointers wrap modulo DEPTH (power of two).
module alu_result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: flag formation, result FIFO, NZCV status.
// Optional commit/overflow counters with ALU_RESULT_STATS_EN.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [4:0]       in_aluop,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_cout,
  input  logic             in_neg,
  input  logic             in_ovf,
  input  logic             in_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags,
  output logic [3:0]       status_nzcv
`ifdef ALU_RESULT_STATS_EN
  ,
  output logic [31:0]      stat_commits,
  output logic [31:0]      stat_ovf
`endif
);

  localparam int PW = WIDTH + TAG_W + 6;

  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [3:0]    in_flags;
  logic [PW-1:0] wdata;
  logic [PW-1:0] rdata;
  logic          head_upd;
  logic          head_arith;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    in_flags = '0;
    if (is_arith(in_aluop)) begin
      in_flags[FLG_N] = in_neg;
      in_flags[FLG_Z] = in_zero;
      in_flags[FLG_C] = in_cout;
      in_flags[FLG_V] = in_ovf;
    end else begin
      in_flags[FLG_N] = in_result[WIDTH-1];
      in_flags[FLG_Z] = (in_result == '0);
    end
  end

  // Opcode class is resolved at push so the pop path stays shallow.
  assign wdata = {is_defined(in_aluop),
                  is_arith(in_aluop),
                  in_flags, in_tag, in_result};

  alu_result_fifo #(
    .W     (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  assign {head_upd, head_arith,
          out_flags, out_tag, out_result} = rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      status_nzcv <= '0;
    else if (pop && head_upd)
      status_nzcv <= out_flags;
  end

`ifdef ALU_RESULT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_commits <= '0;
      stat_ovf     <= '0;
    end else if (pop) begin
      stat_commits <= stat_commits + 32'd1;
      if (head_arith && out_flags[FLG_V])
        stat_ovf <= stat_ovf + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed, table-driven bench for alu_result_stage.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [4:0]  in_aluop;
  logic [4:0]  in_tag;
  logic        in_cout;
  logic        in_neg;
  logic        in_ovf;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic [3:0]  out_flags;
  logic [3:0]  status_nzcv;
`ifdef ALU_RESULT_STATS_EN
  logic [31:0] stat_commits;
  logic [31:0] stat_ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int exp_commits = 0;
  int exp_ovf = 0;

  always #5 clk = ~clk;

  alu_result_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_aluop    (in_aluop),
    .in_tag      (in_tag),
    .in_cout     (in_cout),
    .in_neg      (in_neg),
    .in_ovf      (in_ovf),
    .in_zero     (in_zero),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_tag     (out_tag),
    .out_flags   (out_flags),
    .status_nzcv (status_nzcv)
`ifdef ALU_RESULT_STATS_EN
    ,
    .stat_commits(stat_commits),
    .stat_ovf    (stat_ovf)
`endif
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] res;
    logic [4:0]  tag;
    logic        c;
    logic        n;
    logic        v;
    logic        z;
    logic [3:0]  flags;
    logic [3:0]  status;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op,
                       input logic [31:0] res,
                       input logic [4:0] tag,
                       input logic c, n, v, z);
    in_valid  = 1'b1;
    in_aluop  = op;
    in_result = res;
    in_tag    = tag;
    in_cout   = c;
    in_neg    = n;
    in_ovf    = v;
    in_zero   = z;
  endtask

  task automatic note_pop(input logic [4:0] op,
                          input logic v);
    exp_commits++;
    if ((op == 5'b00001 || op == 5'b00011) && v)
      exp_ovf++;
  endtask

  task automatic chk_stats(input string name);
`ifdef ALU_RESULT_STATS_EN
    chk({name, "_commits"}, stat_commits,
        exp_commits);
    chk({name, "_ovf"}, stat_ovf, exp_ovf);
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  initial begin
    logic [3:0] st;
    // op, result, tag, c, n, v, z, flags, status-after-pop
    vt[0] = '{5'b00001, 32'h0000_0005, 5'd3,
              0, 0, 0, 0, 4'b0000, 4'b0000};
    vt[1] = '{5'b00011, 32'h8000_0000, 5'd7,
              0, 1, 1, 0, 4'b1001, 4'b1001};
    vt[2] = '{5'b00100, 32'h0000_0000, 5'd9,
              1, 0, 0, 0, 4'b0100, 4'b0100};
    vt[3] = '{5'b11111, 32'h8000_0000, 5'd31,
              1, 0, 1, 1, 4'b1000, 4'b0100};
    vt[4] = '{5'b00101, 32'hFFFF_0000, 5'd12,
              1, 0, 1, 1, 4'b1000, 4'b1000};
    vt[5] = '{5'b00000, 32'h0000_0000, 5'd1,
              0, 1, 1, 0, 4'b0100, 4'b1000};
    vt[6] = '{5'b00001, 32'h0000_0000, 5'd20,
              1, 0, 0, 1, 4'b0110, 4'b0110};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    drive(5'd0, 32'd0, 5'd0, 0, 0, 0, 0);
    in_valid = 1'b0;
    #12;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_status", status_nzcv, 0);
    chk("rst_result", out_result, 0);

    // single-entry push then pop per vector
    st = 4'b0000;
    for (int i = 0; i < 7; i++) begin
      drive(vt[i].op, vt[i].res, vt[i].tag,
            vt[i].c, vt[i].n, vt[i].v, vt[i].z);
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_result", i),
          out_result, vt[i].res);
      chk($sformatf("v%0d_tag", i),
          out_tag, vt[i].tag);
      chk($sformatf("v%0d_flags", i),
          out_flags, vt[i].flags);
      chk($sformatf("v%0d_st_hold", i),
          status_nzcv, st);
      out_ready = 1'b1;
      @(negedge clk);
      note_pop(vt[i].op, vt[i].v);
      out_ready = 1'b0;
      chk($sformatf("v%0d_drained", i), out_valid, 0);
      chk($sformatf("v%0d_status", i),
          status_nzcv, vt[i].status);
      st = vt[i].status;
    end
    chk_stats("vec");

    // fill to full, blocked third push, ordered drain
    drive(5'b11111, 32'hAAAA_0001, 5'd1, 0, 0, 0, 0);
    @(negedge clk);
    chk("fill1_in_ready", in_ready, 1);
    drive(5'b11111, 32'hAAAA_0002, 5'd2, 0, 0, 0, 0);
    @(negedge clk);
    chk("fill2_in_ready", in_ready, 0);
    chk("fill2_head", out_result, 32'hAAAA_0001);
    drive(5'b11111, 32'hAAAA_0003, 5'd3, 0, 0, 0, 0);
    out_ready = 1'b1;
    @(negedge clk);
    note_pop(5'b11111, 0);
    in_valid = 1'b0;
    chk("fill3_head", out_result, 32'hAAAA_0002);
    chk("fill3_tag", out_tag, 2);
    chk("fill3_in_ready", in_ready, 1);
    @(negedge clk);
    note_pop(5'b11111, 0);
    out_ready = 1'b0;
    chk("fill_empty", out_valid, 0);
    @(negedge clk);
    chk("fill_no_3rd", out_valid, 0);
    chk("fill_status", status_nzcv, 4'b0110);

    // streaming push+pop at count=1, pointers wrap
    drive(5'b11111, 32'h5000_0000, 5'd0, 0, 0, 0, 0);
    @(negedge clk);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("s%0d_valid", i), out_valid, 1);
      chk($sformatf("s%0d_in_ready", i), in_ready, 1);
      chk($sformatf("s%0d_head", i), out_result,
          32'h5000_0000 + 32'(i - 1));
      chk($sformatf("s%0d_tag", i), out_tag,
          32'(i - 1));
      drive(5'b11111, 32'h5000_0000 + 32'(i),
            5'(i), 0, 0, 0, 0);
      out_ready = 1'b1;
      @(negedge clk);
      note_pop(5'b11111, 0);
    end
    in_valid = 1'b0;
    chk("s_last_head", out_result, 32'h5000_0008);
    @(negedge clk);
    note_pop(5'b11111, 0);
    out_ready = 1'b0;
    chk("s_empty", out_valid, 0);
    chk("s_status", status_nzcv, 4'b0110);
    chk_stats("stream");

    // asynchronous reset with two entries pending
    drive(5'b00001, 32'h8000_0001, 5'd4, 0, 1, 0, 0);
    @(negedge clk);
    drive(5'b00100, 32'h0000_0010, 5'd5, 0, 0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_full", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_status", status_nzcv, 0);
    chk("arst_flags", out_flags, 0);
    chk("arst_tag", out_tag, 0);
    exp_commits = 0;
    exp_ovf = 0;
    chk_stats("arst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
